// File: rtl/ascon_ti_perm_ctrl.sv
// ---------------------------------------------------------------------------
// ascon_ti_perm_ctrl
//
// Sequences a 3-share threshold-implemented Ascon permutation p^R. The TI
// S-box layer is built from three ascon_sub_layer_ti instances. Each round
// takes two cycles:
//   SBOX : add the round constant to share 0, run the TI S-box layer and
//          register the three output shares.
//   LIN  : apply the linear diffusion layer to each share, then remask the
//          shares with a fresh 640-bit random word from the RNG.
// The mode/AEAD FSM talks to this block through start/ready/busy/done. The
// RNG talks to it through rnd/rnd_valid/rnd_ready.
//
// Ports
//   clk        in   1     system clock, rising edge
//   rst_n      in   1     asynchronous active-low reset
//   start      in   1     request a permutation; accepted only when ready=1
//   rounds     in   RW    round count R, sampled with start (0 or >12 -> 12)
//   s0_in      in   320   input share 0, {x0,x1,x2,x3,x4}, x0 at [319:256]
//   s1_in      in   320   input share 1
//   s2_in      in   320   input share 2
//   rnd        in   640   fresh mask {m1,m0}
//   rnd_valid  in   1     rnd holds fresh data
//   rnd_ready  out  1     rnd is consumed when rnd_valid is also high
//   ready      out  1     controller is idle
//   busy       out  1     controller is running rounds
//   done       out  1     one-cycle pulse, results valid from this cycle on
//   s0_out     out  320   result share 0 (held until the next start)
//   s1_out     out  320   result share 1
//   s2_out     out  320   result share 2
// ---------------------------------------------------------------------------

// ---------------------------------------------------------------------------
// ascon_sub_layer_ti
//
// One output share of the threshold-implemented Ascon S-box layer, applied
// bit-sliced across all 64 columns. The chi nonlinearity ~a & b is shared as
//   z_k = a_k b_k ^ a_k b_k+1 ^ a_k+2 b_k+1   (indices mod 3).
// Summed over k, this covers all nine cross products exactly once. When
// shares 1 and 2 are zero, share 0 alone carries the plain S-box result.
//
// Ports
//   s0_i, s1_i, s2_i  in   320  all three input shares
//   y_o               out  320  output share number SHARE
// ---------------------------------------------------------------------------
module ascon_sub_layer_ti #(
  parameter int SHARE = 0
) (
  input  logic [319:0] s0_i,
  input  logic [319:0] s1_i,
  input  logic [319:0] s2_i,
  output logic [319:0] y_o
);

  localparam int KA = SHARE;
  localparam int KB = (SHARE + 1) % 3;
  localparam int KC = (SHARE + 2) % 3;

  logic [319:0] shareIn [3];
  logic [63:0]  pre     [3][5];
  logic [63:0]  notPre  [3][5];
  logic [63:0]  chi     [5];
  logic [63:0]  post    [5];

  assign shareIn[0] = s0_i;
  assign shareIn[1] = s1_i;
  assign shareIn[2] = s2_i;

  // Input linear layer, applied per share. The complement inside chi only
  // goes on share 0, so the shares still XOR to ~x.
  always_comb begin
    for (int s = 0; s < 3; s++) begin
      pre[s][0] = shareIn[s][319:256] ^ shareIn[s][63:0];
      pre[s][1] = shareIn[s][255:192];
      pre[s][2] = shareIn[s][191:128] ^ shareIn[s][255:192];
      pre[s][3] = shareIn[s][127:64];
      pre[s][4] = shareIn[s][63:0] ^ shareIn[s][127:64];
      for (int l = 0; l < 5; l++) begin
        notPre[s][l] = (s == 0) ? ~pre[s][l] : pre[s][l];
      end
    end
  end

  // Shared chi: x_l ^= ~x_l+1 & x_l+2. This instance only produces share KA.
  always_comb begin
    for (int l = 0; l < 5; l++) begin
      chi[l] = pre[KA][l]
             ^ (notPre[KA][(l + 1) % 5] & pre[KA][(l + 2) % 5])
             ^ (notPre[KA][(l + 1) % 5] & pre[KB][(l + 2) % 5])
             ^ (notPre[KC][(l + 1) % 5] & pre[KB][(l + 2) % 5]);
    end
  end

  // Output linear layer. The final inversion of x2 is applied only to share 0.
  always_comb begin
    post[0] = chi[0] ^ chi[4];
    post[1] = chi[1] ^ chi[0];
    post[2] = (SHARE == 0) ? ~chi[2] : chi[2];
    post[3] = chi[3] ^ chi[2];
    post[4] = chi[4];
  end

  assign y_o = {post[0], post[1], post[2], post[3], post[4]};

endmodule

module ascon_ti_perm_ctrl #(
  parameter int MAX_ROUNDS = 12,
  parameter int RW         = 4
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            start,
  input  logic [RW-1:0]   rounds,
  input  logic [319:0]    s0_in,
  input  logic [319:0]    s1_in,
  input  logic [319:0]    s2_in,
  input  logic [639:0]    rnd,
  input  logic            rnd_valid,
  output logic            rnd_ready,
  output logic            ready,
  output logic            busy,
  output logic            done,
  output logic [319:0]    s0_out,
  output logic [319:0]    s1_out,
  output logic [319:0]    s2_out
);

  localparam int CW = $clog2(MAX_ROUNDS);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    SBOX = 2'd1,
    LIN  = 2'd2,
    DONE = 2'd3
  } state_t;

  state_t        state_q, state_d;
  logic [CW-1:0] ctr_q, ctr_d;
  logic [319:0]  share0_q, share0_d;
  logic [319:0]  share1_q, share1_d;
  logic [319:0]  share2_q, share2_d;
  logic          ready_q, busy_q, done_q, rndReady_q;

  logic          roundsFull;
  logic [CW-1:0] ctrStart;
  logic          lastRound;
  logic [3:0]    rcIdx;
  logic [7:0]    roundConst;
  logic [319:0]  sboxIn0;
  logic [319:0]  sbox0, sbox1, sbox2;
  logic [319:0]  mask0, mask1;
  logic [319:0]  lin0, lin1, lin2;

  function automatic logic [63:0] ror64(input logic [63:0] v, input int r);
    return (v >> r) | (v << (64 - r));
  endfunction

  // Ascon linear diffusion layer. It is linear, so it is applied to each
  // share independently.
  function automatic logic [319:0] linLayer(input logic [319:0] s);
    logic [63:0] x0, x1, x2, x3, x4;
    x0 = s[319:256];
    x1 = s[255:192];
    x2 = s[191:128];
    x3 = s[127:64];
    x4 = s[63:0];
    return {x0 ^ ror64(x0, 19) ^ ror64(x0, 28),
            x1 ^ ror64(x1, 61) ^ ror64(x1, 39),
            x2 ^ ror64(x2, 1)  ^ ror64(x2, 6),
            x3 ^ ror64(x3, 10) ^ ror64(x3, 17),
            x4 ^ ror64(x4, 7)  ^ ror64(x4, 41)};
  endfunction

  // Round index runs (MAX_ROUNDS-R)..MAX_ROUNDS-1. Out-of-range counts fall
  // back to the full permutation.
  assign roundsFull = (rounds == '0) || (rounds > RW'(MAX_ROUNDS));
  assign ctrStart   = roundsFull ? '0 : CW'(MAX_ROUNDS) - CW'(rounds);
  assign lastRound  = (ctr_q == CW'(MAX_ROUNDS - 1));

  // Round constant c_i = {15-i, i}. It enters share 0 only, in x2[7:0].
  assign rcIdx      = 4'(ctr_q);
  assign roundConst = {4'd15 - rcIdx, rcIdx};
  assign sboxIn0    = share0_q ^ {184'd0, roundConst, 128'd0};

  ascon_sub_layer_ti #(.SHARE(0)) sub_layer_ti_0 (
    .s0_i (sboxIn0),
    .s1_i (share1_q),
    .s2_i (share2_q),
    .y_o  (sbox0)
  );

  ascon_sub_layer_ti #(.SHARE(1)) sub_layer_ti_1 (
    .s0_i (sboxIn0),
    .s1_i (share1_q),
    .s2_i (share2_q),
    .y_o  (sbox1)
  );

  ascon_sub_layer_ti #(.SHARE(2)) sub_layer_ti_2 (
    .s0_i (sboxIn0),
    .s1_i (share1_q),
    .s2_i (share2_q),
    .y_o  (sbox2)
  );

  // Remasking adds m0, m1 and m0^m1, so the XOR of the shares is unchanged.
  assign mask0 = rnd[319:0];
  assign mask1 = rnd[639:320];
  assign lin0  = linLayer(share0_q) ^ mask0;
  assign lin1  = linLayer(share1_q) ^ mask1;
  assign lin2  = linLayer(share2_q) ^ mask0 ^ mask1;

  // Next-state and datapath selection. LIN waits for the RNG without a
  // timeout. While it waits, the share registers hold their values.
  always_comb begin
    state_d  = state_q;
    ctr_d    = ctr_q;
    share0_d = share0_q;
    share1_d = share1_q;
    share2_d = share2_q;
    unique case (state_q)
      IDLE: begin
        if (start) begin
          share0_d = s0_in;
          share1_d = s1_in;
          share2_d = s2_in;
          ctr_d    = ctrStart;
          state_d  = SBOX;
        end
      end
      SBOX: begin
        share0_d = sbox0;
        share1_d = sbox1;
        share2_d = sbox2;
        state_d  = LIN;
      end
      LIN: begin
        if (rnd_valid) begin
          share0_d = lin0;
          share1_d = lin1;
          share2_d = lin2;
          if (lastRound) begin
            state_d = DONE;
          end else begin
            ctr_d   = ctr_q + CW'(1);
            state_d = SBOX;
          end
        end
      end
      DONE: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // State, counter and share registers. Reset aborts immediately and
  // drops any randomness in flight.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= IDLE;
      ctr_q    <= '0;
      share0_q <= '0;
      share1_q <= '0;
      share2_q <= '0;
    end else begin
      state_q  <= state_d;
      ctr_q    <= ctr_d;
      share0_q <= share0_d;
      share1_q <= share1_d;
      share2_q <= share2_d;
    end
  end

  // Status outputs are registered from the next state. They therefore match
  // the state decode with no combinational path from any input.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ready_q    <= 1'b1;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
      rndReady_q <= 1'b0;
    end else begin
      ready_q    <= (state_d == IDLE);
      busy_q     <= (state_d == SBOX) || (state_d == LIN);
      done_q     <= (state_d == DONE);
      rndReady_q <= (state_d == LIN);
    end
  end

  assign ready     = ready_q;
  assign busy      = busy_q;
  assign done      = done_q;
  assign rnd_ready = rndReady_q;
  assign s0_out    = share0_q;
  assign s1_out    = share1_q;
  assign s2_out    = share2_q;

endmodule

// File: tb/tb_ascon_ti_perm_ctrl.sv
// ---------------------------------------------------------------------------
// tb_ascon_ti_perm_ctrl
//
// Testbench for ascon_ti_perm_ctrl. The stimulus uses random shares and
// random masks. The bench drives and samples on the falling edge, away from
// the active rising edge.
//
// The reference model is the plain, unmasked Ascon permutation. Whatever
// the masks are, the XOR of the output shares must equal p^R of the XOR of
// the input shares.
// ---------------------------------------------------------------------------
module tb_ascon_ti_perm_ctrl;

  logic         clk = 1'b0;
  logic         rst_n;
  logic         start;
  logic [3:0]   rounds;
  logic [319:0] s0_in, s1_in, s2_in;
  logic [639:0] rnd;
  logic         rnd_valid;
  logic         rnd_ready, ready, busy, done;
  logic [319:0] s0_out, s1_out, s2_out;

  int testsRun    = 0;
  int testsFailed = 0;

  ascon_ti_perm_ctrl dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .start     (start),
    .rounds    (rounds),
    .s0_in     (s0_in),
    .s1_in     (s1_in),
    .s2_in     (s2_in),
    .rnd       (rnd),
    .rnd_valid (rnd_valid),
    .rnd_ready (rnd_ready),
    .ready     (ready),
    .busy      (busy),
    .done      (done),
    .s0_out    (s0_out),
    .s1_out    (s1_out),
    .s2_out    (s2_out)
  );

  always #5 clk = ~clk;

  // Every comparison goes through this task, which counts it and reports any mismatch.
  task automatic checkOutput(input string tag, input logic [319:0] observed,
                             input logic [319:0] expected);
    testsRun++;
    if (observed !== expected) begin
      testsFailed++;
      $display("[TB] FAIL %s: got %0h, expected %0h", tag, observed, expected);
    end
  endtask

  function automatic logic [319:0] rand320();
    logic [319:0] r;
    r = '0;
    for (int i = 0; i < 10; i++) r = {r[287:0], 32'($urandom())};
    return r;
  endfunction

  function automatic logic [63:0] rotr(input logic [63:0] v, input int r);
    return (v >> r) | (v << (64 - r));
  endfunction

  // Reference Ascon p^R on an unmasked 320-bit state.
  function automatic logic [319:0] asconRef(input logic [319:0] st, input int numRounds);
    logic [63:0] x [5];
    logic [63:0] t [5];
    for (int l = 0; l < 5; l++) x[l] = st[319 - 64*l -: 64];
    for (int i = 12 - numRounds; i < 12; i++) begin
      x[2] ^= 64'((15 - i) * 16 + i);
      x[0] ^= x[4]; x[4] ^= x[3]; x[2] ^= x[1];
      for (int j = 0; j < 5; j++) t[j] = ~x[j] & x[(j + 1) % 5];
      for (int j = 0; j < 5; j++) x[j] ^= t[(j + 1) % 5];
      x[1] ^= x[0]; x[0] ^= x[4]; x[3] ^= x[2]; x[2] = ~x[2];
      x[0] ^= rotr(x[0], 19) ^ rotr(x[0], 28);
      x[1] ^= rotr(x[1], 61) ^ rotr(x[1], 39);
      x[2] ^= rotr(x[2], 1)  ^ rotr(x[2], 6);
      x[3] ^= rotr(x[3], 10) ^ rotr(x[3], 17);
      x[4] ^= rotr(x[4], 7)  ^ rotr(x[4], 41);
    end
    return {x[0], x[1], x[2], x[3], x[4]};
  endfunction

  task automatic checkResetValues(input string tag);
    checkOutput({tag, ".ready"},     320'(ready),     320'(1));
    checkOutput({tag, ".busy"},      320'(busy),      320'(0));
    checkOutput({tag, ".done"},      320'(done),      320'(0));
    checkOutput({tag, ".rnd_ready"}, 320'(rnd_ready), 320'(0));
    checkOutput({tag, ".s0_out"},    s0_out,          320'(0));
    checkOutput({tag, ".s1_out"},    s1_out,          320'(0));
    checkOutput({tag, ".s2_out"},    s2_out,          320'(0));
  endtask

  // Runs one permutation and checks it against the model.
  // stallAt/stallLen hold rnd_valid low for stallLen cycles once stallAt
  // words have been consumed. pokeStart pulses start while busy and in DONE.
  task automatic applyStimulus(input string tag, input logic [319:0] a0,
                               input logic [319:0] a1, input logic [319:0] a2,
                               input logic [3:0] roundsIn, input int effR,
                               input bit zeroMasks, input int stallAt,
                               input int stallLen, input bit pokeStart);
    logic [319:0] expXor, held0, held1, held2;
    int handshakes, stallCnt, doneCycle, extraDone;
    expXor     = asconRef(a0 ^ a1 ^ a2, effR);
    handshakes = 0;
    stallCnt   = 0;
    doneCycle  = -1;
    extraDone  = 0;
    @(negedge clk);
    checkOutput({tag, ".readyBeforeStart"}, 320'(ready), 320'(1));
    s0_in = a0; s1_in = a1; s2_in = a2;
    rounds = roundsIn;
    start = 1'b1;
    rnd_valid = 1'b0;
    for (int n = 1; n <= 200 && doneCycle < 0; n++) begin
      @(negedge clk);
      start  = pokeStart && (n == 2);
      s0_in  = rand320(); s1_in = rand320(); s2_in = rand320();
      rounds = 4'($urandom_range(1, 15));
      if (n == 1) begin
        checkOutput({tag, ".busyFirst"},  320'(busy),  320'(1));
        checkOutput({tag, ".readyFirst"}, 320'(ready), 320'(0));
      end
      if (done) begin
        doneCycle = n;
        checkOutput({tag, ".readyInDone"}, 320'(ready), 320'(0));
        checkOutput({tag, ".busyInDone"},  320'(busy),  320'(0));
        start     = pokeStart;
        rnd_valid = 1'b0;
      end else if (rnd_ready) begin
        if (handshakes == stallAt && stallCnt < stallLen) begin
          rnd_valid = 1'b0;
          rnd       = {rand320(), rand320()};
          stallCnt++;
        end else begin
          rnd_valid = 1'b1;
          rnd       = zeroMasks ? 640'd0 : {rand320(), rand320()};
          handshakes++;
        end
      end else begin
        rnd_valid = 1'($urandom_range(0, 1));
        rnd       = {rand320(), rand320()};
      end
    end
    checkOutput({tag, ".latency"},    320'(doneCycle),  320'(1 + 2*effR + stallLen));
    checkOutput({tag, ".xorResult"},  s0_out ^ s1_out ^ s2_out, expXor);
    checkOutput({tag, ".handshakes"}, 320'(handshakes), 320'(effR));
    if (zeroMasks) begin
      checkOutput({tag, ".s0Plain"}, s0_out, expXor);
      checkOutput({tag, ".s1Zero"},  s1_out, 320'(0));
    end
    held0 = s0_out; held1 = s1_out; held2 = s2_out;
    @(negedge clk);
    start = 1'b0;
    checkOutput({tag, ".readyAfter"}, 320'(ready), 320'(1));
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      if (done || busy) extraDone++;
    end
    checkOutput({tag, ".noSecondRun"}, 320'(extraDone), 320'(0));
    checkOutput({tag, ".heldOut"}, s0_out ^ s1_out ^ s2_out, held0 ^ held1 ^ held2);
  endtask

  initial begin
    logic [319:0] r0, r1, r2;
    int effR;
    rst_n = 1'b0; start = 1'b0; rounds = 4'd12; rnd_valid = 1'b0; rnd = '0;
    s0_in = '0; s1_in = '0; s2_in = '0;
    repeat (2) @(negedge clk);
    checkResetValues("reset");
    rst_n = 1'b1;

    applyStimulus("p12Unmasked", rand320(), 320'd0, 320'd0, 4'd12, 12, 1'b1, -1, 0, 1'b0);
    applyStimulus("p8", rand320(), rand320(), rand320(), 4'd8, 8, 1'b0, -1, 0, 1'b0);
    applyStimulus("p6", rand320(), rand320(), rand320(), 4'd6, 6, 1'b0, -1, 0, 1'b0);
    applyStimulus("r1Zero", 320'd0, 320'd0, 320'd0, 4'd1, 1, 1'b0, -1, 0, 1'b0);
    applyStimulus("r12Zero", 320'd0, 320'd0, 320'd0, 4'd12, 12, 1'b0, -1, 0, 1'b0);
    applyStimulus("stall", rand320(), rand320(), rand320(), 4'd12, 12, 1'b0, 3, 3, 1'b0);
    applyStimulus("pokeStart", rand320(), rand320(), rand320(), 4'd10, 10, 1'b0, -1, 0, 1'b1);
    applyStimulus("rounds0", rand320(), rand320(), rand320(), 4'd0, 12, 1'b0, -1, 0, 1'b0);
    applyStimulus("rounds15", rand320(), rand320(), rand320(), 4'd15, 12, 1'b0, -1, 0, 1'b0);

    // Abort during the SBOX cycle of round 5, with a random word on offer.
    r0 = rand320(); r1 = rand320(); r2 = rand320();
    @(negedge clk);
    s0_in = r0; s1_in = r1; s2_in = r2; rounds = 4'd12; start = 1'b1;
    for (int n = 1; n < 9; n++) begin
      @(negedge clk);
      start     = 1'b0;
      rnd_valid = rnd_ready;
      rnd       = {rand320(), rand320()};
    end
    @(negedge clk);
    rnd_valid = 1'b1;
    rst_n     = 1'b0;
    #1;
    checkResetValues("abort");
    @(negedge clk);
    checkResetValues("abortHeld");
    rst_n = 1'b1;
    rnd_valid = 1'b0;
    applyStimulus("afterAbort", r0, r1, r2, 4'd12, 12, 1'b0, -1, 0, 1'b0);

    for (int t = 0; t < 4; t++) begin
      effR = $urandom_range(1, 12);
      applyStimulus($sformatf("rand%0d", t), rand320(), rand320(), rand320(),
                    4'(effR), effR, 1'b0, $urandom_range(0, effR - 1),
                    $urandom_range(0, 4), 1'($urandom_range(0, 1)));
    end

    $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
    $finish;
  end

endmodule
